// File: rtl/queue_ctrl.sv
// Queue pointer/occupancy controller in front of an external 8-entry register file.
// The head entry is read combinationally from the register file; pushes write it directly.
module queue_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             rf_wr,
  output logic [2:0]       rf_wr_addr,
  output logic [WIDTH-1:0] rf_d_in,
  output logic [2:0]       rf_rd_addr,
  input  logic [WIDTH-1:0] rf_d_out,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [2:0] head_q, head_d, tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d, udf_q, udf_d;
  logic       push_fire, pop_fire;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == 4'd0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  assign rf_wr      = push_fire;
  assign rf_wr_addr = tail_q;
  assign rf_d_in    = push_data;
  assign rf_rd_addr = head_q;
  assign pop_data   = rf_d_out;

  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      // flush wins over any transfer in the same cycle
      head_d  = 3'd0;
      tail_d  = 3'd0;
      count_d = 4'd0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push_fire) tail_d = tail_q + 3'd1;
      if (pop_fire)  head_d = head_q + 3'd1;
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
      if (push_valid && full) ovf_d = 1'b1;
      if (pop_ready && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl: stimulus updates a queue-level reference model,
// a negedge monitor compares every DUT output and pops expected data on each pop.
module tb_queue_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] push_data = 16'h0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [15:0] pop_data;
  logic        rf_wr;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_d_in;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_d_out;
  logic [3:0]  count;
  logic        full, empty, ovf, udf;

  queue_ctrl #(.DEPTH(8), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .rf_rd_addr(rf_rd_addr), .rf_d_out(rf_d_out),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // external 8x16 register file
  logic [15:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'h0;
  always @(posedge clk) if (rf_wr) mem[rf_wr_addr] <= rf_d_in;
  assign rf_d_out = mem[rf_rd_addr];

  // reference model
  int          m_count = 0;
  int          m_head  = 0;
  int          m_tail  = 0;
  bit          m_ovf   = 0;
  bit          m_udf   = 0;
  logic [15:0] exp_q[$];

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  mon_en = 0;
  bit  exp_pf;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    m_count = 0; m_head = 0; m_tail = 0; m_ovf = 0; m_udf = 0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_pf = push_valid && (m_count < 8);
      chk("count", int'(count), m_count);
      chk("full", int'(full), int'(m_count == 8));
      chk("empty", int'(empty), int'(m_count == 0));
      chk("push_ready", int'(push_ready), int'(m_count < 8));
      chk("pop_valid", int'(pop_valid), int'(m_count > 0));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("udf", int'(udf), int'(m_udf));
      chk("rf_wr", int'(rf_wr), int'(exp_pf));
      chk("rf_rd_addr", int'(rf_rd_addr), m_head);
      if (exp_pf) begin
        chk("rf_wr_addr", int'(rf_wr_addr), m_tail);
        chk("rf_d_in", int'(rf_d_in), int'(push_data));
      end
      if (pop_valid && pop_ready) begin
        if (exp_q.size() == 0) chk("pop_underrun", 1, 0);
        else chk("pop_data", int'(pop_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Drive one cycle of inputs (from posedge+1), then advance the model at the edge.
  task automatic step(input bit pv, input logic [15:0] pd, input bit pr, input bit fl);
    bit pf, qf;
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    @(posedge clk);
    pf = pv && (m_count < 8);
    qf = pr && (m_count > 0);
    if (fl) model_clear();
    else begin
      if (pv && m_count == 8) m_ovf = 1;
      if (pr && m_count == 0) m_udf = 1;
      if (pf) begin exp_q.push_back(pd); m_tail = (m_tail + 1) % 8; end
      if (qf) m_head = (m_head + 1) % 8;
      m_count = m_count + int'(pf) - int'(qf);
    end
    #1;
    push_valid = 0; pop_ready = 0; flush = 0;
  endtask

  task automatic push(input logic [15:0] d); step(1, d, 0, 0); endtask
  task automatic pop(); step(0, 16'h0, 1, 0); endtask

  initial begin
    // power-on reset
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_pop_valid", int'(pop_valid), 0);
    chk("rst_rf_wr", int'(rf_wr), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1;

    // three pushes then three pops
    push(16'h1111); push(16'h2222); push(16'h3333);
    repeat (3) pop();
    step(0, 16'h0, 0, 0);

    // fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i));
    push(16'hBEEF);
    step(0, 16'h0, 0, 0);
    repeat (8) pop();
    step(0, 16'h0, 0, 1);

    // wrap-around: pointers start at 6 after 6+6
    for (int i = 0; i < 6; i++) push(16'h6000 + 16'(i));
    repeat (6) pop();
    for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i));
    repeat (4) pop();

    // simultaneous push/pop at count 3, then empty push+pop
    for (int i = 0; i < 3; i++) push(16'h3000 + 16'(i));
    step(1, 16'h3ABC, 1, 0);
    step(0, 16'h0, 0, 0);
    repeat (3) pop();
    step(1, 16'h1E1E, 1, 0);
    step(0, 16'h0, 0, 0);
    pop();
    step(0, 16'h0, 0, 1);

    // count 5 with ovf set, then asynchronous reset between edges
    for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
    push(16'hDEAD);
    repeat (3) pop();
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_ovf", int'(ovf), 0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    push(16'h5A5A);
    pop();

    // flush with count 4 and both sides firing
    for (int i = 0; i < 4; i++) push(16'hF000 + 16'(i));
    step(1, 16'hF0F0, 1, 1);
    step(0, 16'h0, 0, 0);
    push(16'h1234);
    pop();

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 40) == 0));
    repeat (10) pop();

    @(negedge clk); #1;
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
